// File: rtl/audio_pwm_out_if.sv
// Sample-word handshake between the audio producer and audio_pwm_out.
// The producer side (master) offers a 32-bit word with a strobe and the
// consumer side (slave) answers with an acknowledge; a word moves on any
// clock edge where stb and ack are both high.
interface audio_pwm_out_if;
  logic [31:0] input_audio;
  logic        input_audio_stb;
  logic        input_audio_ack;

  modport master (
    output input_audio,
    output input_audio_stb,
    input  input_audio_ack
  );

  modport slave (
    input  input_audio,
    input  input_audio_stb,
    output input_audio_ack
  );
endinterface

// File: rtl/audio_pwm_out.sv
// audio_pwm_out: buffers 16-bit signed PCM samples in a small FIFO, releases
// one sample every SAMPLE_DIV clocks and turns it into a PWM waveform for the
// mono AUD_PWM pin. Also drives the amplifier enable AUD_SD.
//
// Build option: define AUDIO_PWM_UNDERRUN_MUTE_EN to load mid-scale silence
// (0x0000) on an underrun tick; otherwise the previous sample is held.
module audio_pwm_out #(
  parameter int SAMPLE_DIV = 2083,
  parameter int PWM_BITS   = 8,
  parameter int FIFO_AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  audio_pwm_out_if.slave   in_if,
  output logic             audio_pwm,
  output logic             audio_sd,
  output logic             underrun
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(SAMPLE_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);

  logic [15:0]        mem_q [DEPTH];
  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [15:0]        sample_q, sample_d;
  logic               audio_pwm_q, audio_pwm_d;
  logic               audio_sd_q, audio_sd_d;

  logic               full;
  logic               empty;
  logic               push;
  logic               tick;
  logic [15:0]        offset_bin;
  logic [PWM_BITS-1:0] duty;
  logic               unused_hi;

  // Upper half of the sample word carries nothing for a mono 16-bit output.
  assign unused_hi = ^in_if.input_audio[31:16];

  // FIFO status, sample tick and handshake decode from registered state only.
  always_comb begin
    full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
            (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    empty = (wr_ptr_q == rd_ptr_q);
    tick  = (tick_cnt_q == TICK_LAST);
    in_if.input_audio_ack = !full && !rst;
    push  = in_if.input_audio_stb && in_if.input_audio_ack;
    underrun = tick && empty && !rst;
  end

  // Signed PCM to offset binary, keeping the top PWM_BITS bits as the duty.
  always_comb begin
    offset_bin = {~sample_q[15], sample_q[14:0]};
    duty       = PWM_BITS'(offset_bin >> (16 - PWM_BITS));
  end

  // Next-state logic for pointers, timers, sample and registered outputs.
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + (FIFO_AW+1)'(1) : wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
    sample_d   = sample_q;
    if (tick) begin
      if (!empty) begin
        sample_d = mem_q[rd_ptr_q[FIFO_AW-1:0]];
        rd_ptr_d = rd_ptr_q + (FIFO_AW+1)'(1);
      end else begin
`ifdef AUDIO_PWM_UNDERRUN_MUTE_EN
        sample_d = 16'h0000;
`else
        sample_d = sample_q;
`endif
      end
    end
    audio_pwm_d = (pwm_cnt_q < duty);
    audio_sd_d  = 1'b1;
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= in_if.input_audio[15:0];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tick_cnt_q  <= '0;
      pwm_cnt_q   <= '0;
      sample_q    <= 16'h0000;
      audio_pwm_q <= 1'b0;
      audio_sd_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tick_cnt_q  <= tick_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      sample_q    <= sample_d;
      audio_pwm_q <= audio_pwm_d;
      audio_sd_q  <= audio_sd_d;
    end
  end

  // Registered pin drivers.
  assign audio_pwm = audio_pwm_q;
  assign audio_sd  = audio_sd_q;

endmodule

// File: doc/audio_pwm_out.md
# audio_pwm_out

Downstream consumer of the `output_audio` stream leaving `user_design` on the Nexys 4 audio build. It accepts 32-bit sample words over the stb/ack handshake into a small FIFO and releases one sample per fixed sample period. Each sample becomes a pulse-width-modulated signal on the board's mono `AUD_PWM` pin, and the block also drives the amplifier shutdown pin `AUD_SD`. Its job is to decouple the software-paced producer from the hard real-time sample clock.

## Interface
Parameters:
- `SAMPLE_DIV`, default 2083: `clk` cycles per audio sample (100 MHz / 2083 ≈ 48 kHz); legal range ≥ 2^`PWM_BITS`.
- `PWM_BITS`, default 8: PWM resolution; the PWM period is 2^`PWM_BITS` clocks.
- `FIFO_AW`, default 4: log2 of FIFO depth (default 16 words).

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `input_audio`  in  32  sample word; bits [15:0] are signed two's-complement PCM and bits [31:16] are ignored.
- `input_audio_stb`  in  1  producer has a valid word.
- `input_audio_ack`  out  1  block accepts the word; a transfer occurs on a clock edge with stb && ack.
- `audio_pwm`  out  1  PWM output to `AUD_PWM`, registered.
- `audio_sd`  out  1  amplifier enable (1 = on), registered.
- `underrun`  out  1  one-cycle pulse when a sample tick finds the FIFO empty.

## Operation
- **FIFO:** 2^`FIFO_AW` × 16 bits, with read/write pointers of `FIFO_AW`+1 bits.
  - Full when the pointer MSBs differ and the remaining bits are equal; empty when the pointers are equal.
- **Handshake:**
  - `input_audio_ack` = !full, decoded combinationally from registered pointers only; it never depends on `input_audio_stb`.
  - On a transfer, `input_audio[15:0]` is written and the write pointer increments, wrapping naturally.
- **Sample timer:**
  - `tick_cnt` counts 0..`SAMPLE_DIV`-1 and wraps.
  - `tick` is asserted for the cycle in which `tick_cnt` == `SAMPLE_DIV`-1.
- **On tick:**
  - FIFO not empty: pop the head word into `sample` and increment the read pointer.
  - FIFO empty: no pop, `underrun` = 1 for exactly that cycle, and `sample` follows the Configuration rule.
- **Conversion:** `duty` = {~sample[15], sample[14:16-`PWM_BITS`]}. The MSB is inverted to get offset binary, then the value is truncated to `PWM_BITS`.
  - 0x8000 → `duty` 0.
  - 0x0000 → 2^(`PWM_BITS`-1).
  - 0x7FFF → 2^`PWM_BITS`-1.
- **PWM:**
  - Free-running `pwm_cnt` of `PWM_BITS` bits.
  - `audio_pwm` is registered as (`pwm_cnt` < `duty`).
  - `duty` 0 gives a constant low output; the maximum duty gives low for one clock per period.
  - `duty` updates immediately, mid-period. No glitch beyond one period is permitted.
- **Simultaneous events:**
  - Push and pop in the same cycle when not full: both happen and the count is unchanged.
  - Push on the tick cycle with the FIFO empty: the pop sees empty (underrun), and the pushed word is stored for the next tick.
  - A push at full is impossible because ack is low.
- **Reset mid-operation:** all FIFO contents are discarded and state returns to the reset values below. A word offered during reset is not acknowledged.

## Timing
- Reset values:
  - Pointers 0, `tick_cnt` 0, `pwm_cnt` 0.
  - `sample` 0x0000, so `duty` = mid-scale.
  - `audio_pwm` 0, `audio_sd` 0, `underrun` 0.
- `input_audio_ack` reads 1 combinationally while `rst` is low and the FIFO is empty. It is forced to 0 while `rst` = 1.
- `audio_sd` goes to 1 on the first clock edge after `rst` deasserts and stays at 1.
- First tick falls `SAMPLE_DIV` cycles after reset release.
- Latency:
  - A word pushed at least one cycle before a tick is loaded into `sample` at that tick.
  - `duty` takes effect in the same cycle.
  - `audio_pwm` reflects the new duty one clock later.
- Throughput: 1 word/clock accepted until full; drained at 1 word per `SAMPLE_DIV` clocks.

## Configuration
- `AUDIO_PWM_UNDERRUN_MUTE_EN`:
  - Defined: on an underrun tick, `sample` is loaded with 0x0000 (mid-scale silence).
  - Undefined: on an underrun tick, `sample` holds its previous value.
- The `underrun` pulse is generated in both builds.

## Test plan
All scenarios use `SAMPLE_DIV`=300, `PWM_BITS`=8, `FIFO_AW`=2.
- **Reset:** after reset, `audio_pwm` duty is 128/256, `audio_sd` is 0 during reset and 1 on the next cycle, and ack is 1.
- **FIFO fill:** push 0x7FFF, 0x8000, 0x0000, 0x4000 back-to-back with stb held. Ack must drop after the 4th word, and a 5th word must not be accepted until the first tick pops.
- **Drain:** over successive ticks, the measured high count per 256-cycle period is 255, then 0, then 128, then 192.
- **Underrun:** after the FIFO drains, the next tick pulses `underrun` for 1 cycle.
  - With the macro defined: duty becomes 128.
  - With the macro undefined: duty stays 192.
- **Simultaneous push and tick:** stb asserted exactly on a tick cycle with the FIFO empty must give `underrun` = 1 and the word stored. The following tick loads that word with no underrun.
- **Reset mid-stream:** with 3 words queued, pulse `rst` for 1 cycle. The FIFO must read empty, ack must be 1, duty must be 128, and no queued sample may appear at later ticks.
